// File: rtl/cave_gfx_pkg.sv
// cave_gfx_pkg: shared pixel-format encoding, unpacker states and tile geometry defaults
package cave_gfx_pkg;
  localparam int DEFAULT_ROW_PIXELS = 16;
  typedef enum logic {
    PIX_4BPP = 1'b0,
    PIX_8BPP = 1'b1
  } pix_mode_e;
  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EMIT_LO,
    ST_EMIT_HI
  } unpack_state_e;
endpackage

// File: rtl/tile_pixel_unpacker.sv
// tile_pixel_unpacker: pops packed bytes from a serializer and emits one pixel per handshake with row tracking
module tile_pixel_unpacker
  import cave_gfx_pkg::*;
#(
  parameter int ROW_PIXELS = DEFAULT_ROW_PIXELS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode_8bpp,
  input  logic       piso_is_empty,
  input  logic [7:0] piso_dout,
  output logic       piso_rd,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic [7:0] pix_data,
  output logic       pix_eor,
  output logic       busy
);
  localparam int RW = $clog2(ROW_PIXELS) + 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW_PIXELS - 1);

  unpack_state_e state_q, state_d;
  logic [7:0] byte_q, byte_d;
  pix_mode_e mode_q, mode_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic xfer, last_pix;

  // Pixel select, handshake and refetch decisions; the mode is sampled only for the first byte of a row
  always_comb begin
    pix_valid = state_q != ST_FETCH;
    pix_data = state_q == ST_EMIT_HI ? {4'h0, byte_q[7:4]} :
               state_q == ST_EMIT_LO ? (mode_q == PIX_8BPP ? byte_q : {4'h0, byte_q[3:0]}) : 8'h00;
    pix_eor = pix_valid && row_cnt_q == ROW_LAST;
    busy = pix_valid || row_cnt_q != '0;
    xfer = pix_valid && pix_ready;
    last_pix = state_q == ST_EMIT_HI || mode_q == PIX_8BPP;
    row_cnt_d = xfer ? (row_cnt_q == ROW_LAST ? '0 : row_cnt_q + 1'b1) : row_cnt_q;
    piso_rd = !reset && !piso_is_empty && (state_q == ST_FETCH || (xfer && last_pix));
    state_d = piso_rd ? ST_EMIT_LO : xfer ? (last_pix ? ST_FETCH : ST_EMIT_HI) : state_q;
    byte_d = piso_rd ? piso_dout : byte_q;
    mode_d = piso_rd && row_cnt_d == '0 ? pix_mode_e'(mode_8bpp) : mode_q;
  end

  // State, held byte, row mode and row position registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FETCH;
      byte_q <= 8'h00;
      mode_q <= PIX_4BPP;
      row_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      byte_q <= byte_d;
      mode_q <= mode_d;
      row_cnt_q <= row_cnt_d;
    end
  end
endmodule

// File: tb/tb_tile_pixel_unpacker.sv
// tb_tile_pixel_unpacker: directed scoreboard bench for the tile pixel unpacker
module tb_tile_pixel_unpacker;
  localparam int ROW = 16;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic mode_8bpp = 1'b0;
  logic piso_is_empty = 1'b1;
  logic [7:0] piso_dout = 8'h00;
  logic piso_rd, pix_valid, pix_eor, busy;
  logic pix_ready = 1'b0;
  logic [7:0] pix_data;
  logic [7:0] up_q[$];
  logic [8:0] exp_q[$];
  int total = 0, bad = 0, rd_cnt = 0, xf_cnt = 0, cyc = 0;
  int seg_first = -1, seg_last = -1, exp_cnt = 0, r0 = 0, base = 0;
  bit mon_en = 1'b0;
  logic prev_stall = 1'b0;
  logic [8:0] prev_px = '0;

  tile_pixel_unpacker #(.ROW_PIXELS(ROW)) dut (
    .clock(clock), .reset(reset), .mode_8bpp(mode_8bpp),
    .piso_is_empty(piso_is_empty), .piso_dout(piso_dout), .piso_rd(piso_rd),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_eor(pix_eor), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // upstream serializer model: pops on piso_rd, presents its head byte
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (piso_rd) begin
      rd_cnt <= rd_cnt + 1;
      void'(up_q.pop_front());
    end
    piso_is_empty <= up_q.size() == 0;
    piso_dout <= up_q.size() != 0 ? up_q[0] : 8'h00;
  end

  // output monitor: scoreboard compare on transfer, stall stability, no pop while empty
  always @(negedge clock) begin
    logic [8:0] e;
    if (mon_en) begin
      if (piso_rd) chk("rd_while_empty", piso_is_empty, 0);
      if (prev_stall && pix_valid) chk("stall_hold", {pix_eor, pix_data}, prev_px);
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) chk("extra_pixel", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("pix", {pix_eor, pix_data}, e);
        end
        xf_cnt++;
        if (seg_first < 0) seg_first = cyc;
        seg_last = cyc;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_px = {pix_eor, pix_data};
    end else prev_stall = 1'b0;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic add_exp(input logic [7:0] d);
    exp_q.push_back({exp_cnt == ROW - 1, d});
    exp_cnt = exp_cnt == ROW - 1 ? 0 : exp_cnt + 1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit m8);
    up_q.push_back(b);
    if (m8) add_exp(b);
    else begin
      add_exp({4'h0, b[3:0]});
      add_exp({4'h0, b[7:4]});
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step();
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 50 && pix_valid !== 1'b1; i++) step();
    chk(tag, pix_valid, 1);
  endtask

  initial begin
    step();
    step();
    chk("rst_valid", pix_valid, 0);
    chk("rst_rd", piso_rd, 0);
    chk("rst_eor", pix_eor, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", pix_data, 8'h00);
    reset = 1'b0;
    mon_en = 1'b1;
    pix_ready = 1'b1;
    r0 = rd_cnt;
    seg_first = -1;
    push_byte(8'hA5, 1'b0);
    drain("a5_drain");
    chk("a5_span", seg_last - seg_first, 1);
    chk("a5_rd", rd_cnt - r0, 1);
    for (int i = 0; i < 7; i++) push_byte(8'h10 + 8'(i), 1'b0);
    drain("row0_drain");
    chk("row0_busy", busy, 0);
    mode_8bpp = 1'b1;
    r0 = rd_cnt;
    seg_first = -1;
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
    drain("b2b_drain");
    chk("b2b_span", seg_last - seg_first, 15);
    chk("b2b_rd", rd_cnt - r0, 16);
    mode_8bpp = 1'b0;
    pix_ready = 1'b0;
    r0 = rd_cnt;
    push_byte(8'h96, 1'b0);
    push_byte(8'h78, 1'b0);
    wait_valid("stall_valid");
    for (int i = 0; i < 5; i++) begin
      chk("stall_data", pix_data, 8'h06);
      chk("stall_rd", piso_rd, 0);
      step();
    end
    chk("stall_rd_cnt", rd_cnt - r0, 1);
    pix_ready = 1'b1;
    drain("stall_drain");
    chk("stall_rd_total", rd_cnt - r0, 2);
    for (int i = 0; i < 6; i++) push_byte(8'h20 + 8'(i), 1'b0);
    drain("row2_drain");
    r0 = rd_cnt;
    base = xf_cnt;
    for (int i = 0; i < 8; i++) push_byte(8'h90 + 8'(i), 1'b0);
    for (int i = 0; i < 100 && xf_cnt - base < 3; i++) step();
    chk("toggle_reached", xf_cnt - base >= 3, 1);
    mode_8bpp = 1'b1;
    drain("toggle_drain");
    chk("toggle_rd", rd_cnt - r0, 8);
    r0 = rd_cnt;
    for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i), 1'b1);
    drain("newmode_drain");
    chk("newmode_rd", rd_cnt - r0, 16);
    mode_8bpp = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(8'h51 + 8'(i), 1'b0);
    drain("gap_drain");
    chk("gap_valid", pix_valid, 0);
    chk("gap_busy", busy, 1);
    chk("gap_row_cnt", dut.row_cnt_q, 6);
    for (int i = 0; i < 5; i++) push_byte(8'h61 + 8'(i), 1'b0);
    drain("gap_resume");
    chk("gap_done_busy", busy, 0);
    pix_ready = 1'b0;
    up_q.push_back(8'h3C);
    add_exp(8'h0C);
    wait_valid("rst_lo_valid");
    up_q.push_back(8'h55);
    pix_ready = 1'b1;
    step();
    chk("rst_hi_data", pix_data, 8'h03);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_mid_rd", piso_rd, 0);
    step();
    reset = 1'b0;
    chk("rst_mid_valid", pix_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_nopop", up_q.size(), 1);
    exp_cnt = 0;
    add_exp(8'h05);
    add_exp(8'h05);
    mon_en = 1'b1;
    drain("rst_fresh_drain");
    chk("rst_fresh_row", dut.row_cnt_q, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
